ysyx_23060236_csr_trap_unit: RTL and testbench
==============================================

// Module: ysyx_23060236_csr_trap_unit
// PURPOSE
//  Machine-mode CSR file with trap/interrupt controller for the NPC core; sits at the commit (WB) stage.
//  Adds MIE/MPIE status handling, timer/external interrupts, vectored mtvec and 64-bit mcycle/minstret.
//  Produces the redirect target and enable for ecall, mret and taken interrupts.
// PARAMETERS
//  CNT_W       64            counter width for mcycle/minstret (33..64); upper bits read as zero
//  SYNC_STAGES 2             flop stages on irq_ext before it is visible in mip.MEIP (>=1)
//  VENDOR_ID   32'h79737978  value read at mvendorid
//  ARCH_ID     32'h015fdf0c  value read at marchid
// PORTS
//  clock      in   1   core clock
//  reset      in   1   asynchronous, active-high reset
//  imm        in   12  CSR address of the committing instruction
//  wdata      in   32  CSR write data (already op-merged by EXU)
//  enable     in   1   CSR write request
//  inst_ecall in   1   committing instruction is ecall
//  inst_mret  in   1   committing instruction is mret
//  epc        in   32  PC of the committing instruction
//  valid      in   1   instruction commits this cycle; all state updates gated by it (except counters/sync)
//  irq_timer  in   1   level machine-timer interrupt (already clock-domain-local)
//  irq_ext    in   1   level external interrupt, asynchronous, synchronised internally
//  rdata      out  32  combinational read of CSR at imm
//  jump       out  32  redirect target
//  jump_en    out  1   redirect this cycle
//  irq_take   out  1   interrupt taken; pipeline must squash the committing instruction
//  mmu_on     out  1   satp[31]
//  ppn        out  20  satp[19:0]
// BEHAVIOUR
//  Map: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344, satp 180,
//   mcycle B00, minstret B02, mcycleh B80, minstreth B82, mvendorid F11, marchid F12. Other: rdata 0, writes dropped.
//  Reset (async): mstatus MIE=0,MPIE=0,MPP=2'b11 (reads 0x1800); all other regs 0; sync chain 0. Outputs derive from these:
//   rdata per imm, jump_en=0 (valid low), irq_take=0, mmu_on=0, ppn=0.
//  Field rules: mstatus writable bits MIE[3], MPIE[7] only; MPP fixed 11. mie writable MTIE[7], MEIE[11] only.
//   mip read-only: MTIP[7]=irq_timer, MEIP[11]=synchronised irq_ext. mepc[1:0] forced 0. mtvec[1] forced 0.
//   mcause stored as {intr, code[5:0]}, read {intr,25'b0,code}. mcycleh/minstreth return bits [CNT_W-1:32], zero-ext.
//  irq_take = valid & MIE & ((MEIP&MEIE)|(MTIP&MTIE)). Priority per commit: irq_take > ecall > mret > CSR write.
//  Interrupt: mepc<=epc (instruction re-executes), mcause<={1,11} ext or {1,7} timer (ext wins),
//   MPIE<=MIE, MIE<=0; CSR write/ecall/mret of that instruction ignored; minstret not incremented.
//  ecall: mepc<=epc, mcause<={0,11}, MPIE<=MIE, MIE<=0. mret: MIE<=MPIE, MPIE<=1.
//  jump: interrupt & mtvec[0]=1 -> {mtvec[31:2],2'b0}+4*code; other traps -> {mtvec[31:2],2'b0}; mret -> mepc.
//  jump_en = valid & (irq_take|inst_ecall|inst_mret); combinational, same cycle, uses pre-update register values.
//  CSR writes take effect at the clock edge; rdata reflects new value next cycle. Read of same CSR in write cycle
//   returns old value.
//  mcycle: +1 every cycle including valid low; wraps 2^CNT_W-1 -> 0. A write to mcycle/mcycleh replaces that
//   32-bit half and suppresses that cycle's increment. minstret: +1 per commit without irq_take; same write rule.
//  Low-half write on a cycle with carry: written half taken, upper half unchanged (no carry from written value).
//  irq_ext visible in mip exactly SYNC_STAGES edges after it rises; deassertion same latency.
//  Reset mid-operation clears everything immediately irrespective of valid/clock.
// TESTING
//  Reset then read 300/304/B00 -> 0x1800, 0, then mcycle counts 1,2,3 on consecutive cycles.
//  Write mtvec=0x80000101 (vectored), mie=0x80, mstatus=0x8; assert irq_timer, valid -> irq_take=1, jump=0x8000011C,
//   mcause reads 0x80000007, mstatus reads 0x1880, mepc=epc.
//  ecall at epc=0x80000010 with MIE=1 -> jump=mtvec base, mcause=11, mstatus 0x1880; then mret -> jump=0x80000010, mstatus 0x1888.
//  irq_ext pulse with MEIE set and irq_timer both high -> taken after SYNC_STAGES edges, cause 11 (ext wins), timer ignored.
//  mcycle=0xFFFFFFFF, mcycleh=0 -> next cycle reads mcycle 0, mcycleh 1; write mcycle=5 -> next read 5 (no +1).
//  satp write 0x80012345 -> mmu_on=1, ppn=0x12345 next cycle; async reset mid-trap clears mmu_on, jump_en low.

Source files
------------

// File: rtl/ysyx_23060236_csr_trap_unit.sv
// Machine-mode CSR file and trap/interrupt controller at the commit stage.
// Latency: reads and redirect are combinational; CSR writes land at the next edge; irq_ext takes SYNC_STAGES edges.
// Backpressure: none; every commit is accepted, and a taken interrupt squashes the committing instruction.
module ysyx_23060236_csr_trap_unit #(
  parameter int          CNT_W       = 64,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VENDOR_ID   = 32'h79737978,
  parameter logic [31:0] ARCH_ID     = 32'h015fdf0c
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] imm,
  input  logic [31:0] wdata,
  input  logic        enable,
  input  logic        inst_ecall,
  input  logic        inst_mret,
  input  logic [31:0] epc,
  input  logic        valid,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] rdata,
  output logic [31:0] jump,
  output logic        jump_en,
  output logic        irq_take,
  output logic        mmu_on,
  output logic [19:0] ppn
);
  localparam int HI_W = CNT_W - 32;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic                   r_mie;
  logic                   r_mpie;
  logic                   r_mtie;
  logic                   r_meie;
  logic [31:0]            r_mtvec;
  logic [31:0]            r_mscratch;
  logic [31:0]            r_mepc;
  logic                   r_mcause_intr;
  logic [5:0]             r_mcause_code;
  logic [31:0]            r_satp;
  logic [CNT_W-1:0]       r_mcycle;
  logic [CNT_W-1:0]       r_minstret;
  logic [SYNC_STAGES-1:0] r_sync;

  logic        w_meip;
  logic        w_ext_pend;
  logic        w_tim_pend;
  logic        w_irq_take;
  logic [5:0]  w_irq_code;
  logic        w_ecall;
  logic        w_mret;
  logic        w_csr_we;
  logic [31:0] w_base;
  logic [31:0] w_mcycle_hi;
  logic [31:0] w_minstret_hi;

  assign w_meip     = r_sync[SYNC_STAGES-1];
  assign w_ext_pend = w_meip & r_meie;
  assign w_tim_pend = irq_timer & r_mtie;
  // Reset gating keeps the redirect quiet the instant reset rises, even mid-commit.
  assign w_irq_take = ~reset & valid & r_mie & (w_ext_pend | w_tim_pend);
  assign w_irq_code = w_ext_pend ? 6'd11 : 6'd7;
  assign w_ecall    = valid & inst_ecall & ~w_irq_take;
  assign w_mret     = valid & inst_mret & ~inst_ecall & ~w_irq_take;
  assign w_csr_we   = valid & enable & ~inst_ecall & ~inst_mret & ~w_irq_take;
  assign w_base     = {r_mtvec[31:2], 2'b00};

  assign w_mcycle_hi   = 32'(r_mcycle[CNT_W-1:32]);
  assign w_minstret_hi = 32'(r_minstret[CNT_W-1:32]);

  assign irq_take = w_irq_take;
  assign jump_en  = ~reset & valid & (w_irq_take | inst_ecall | inst_mret);
  assign mmu_on   = r_satp[31];
  assign ppn      = r_satp[19:0];

  // Redirect target from pre-update state; vectored mode only applies to interrupts.
  always_comb begin
    jump = 32'h0;
    if (w_irq_take) begin
      jump = r_mtvec[0] ? (w_base + {24'h0, w_irq_code, 2'b00}) : w_base;
    end else if (w_ecall) begin
      jump = w_base;
    end else if (w_mret) begin
      jump = r_mepc;
    end
  end

  // Combinational CSR read mux; unmapped addresses read zero.
  always_comb begin
    rdata = 32'h0;
    case (imm)
      12'h300: rdata = {19'h0, 2'b11, 3'b000, r_mpie, 3'b000, r_mie, 3'b000};
      12'h304: rdata = {20'h0, r_meie, 3'b000, r_mtie, 7'h00};
      12'h305: rdata = r_mtvec;
      12'h340: rdata = r_mscratch;
      12'h341: rdata = r_mepc;
      12'h342: rdata = {r_mcause_intr, 25'h0, r_mcause_code};
      12'h344: rdata = {20'h0, w_meip, 3'b000, irq_timer, 7'h00};
      12'h180: rdata = r_satp;
      12'hB00: rdata = r_mcycle[31:0];
      12'hB02: rdata = r_minstret[31:0];
      12'hB80: rdata = w_mcycle_hi;
      12'hB82: rdata = w_minstret_hi;
      12'hF11: rdata = VENDOR_ID;
      12'hF12: rdata = ARCH_ID;
      default: rdata = 32'h0;
    endcase
  end

  // Trap entry/exit and CSR write state, in priority order interrupt > ecall > mret > write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mtie        <= 1'b0;
      r_meie        <= 1'b0;
      r_mtvec       <= 32'h0;
      r_mscratch    <= 32'h0;
      r_mepc        <= 32'h0;
      r_mcause_intr <= 1'b0;
      r_mcause_code <= 6'h0;
      r_satp        <= 32'h0;
    end else if (w_irq_take) begin
      r_mepc        <= {epc[31:2], 2'b00};
      r_mcause_intr <= 1'b1;
      r_mcause_code <= w_irq_code;
      r_mpie        <= r_mie;
      r_mie         <= 1'b0;
    end else if (w_ecall) begin
      r_mepc        <= {epc[31:2], 2'b00};
      r_mcause_intr <= 1'b0;
      r_mcause_code <= 6'd11;
      r_mpie        <= r_mie;
      r_mie         <= 1'b0;
    end else if (w_mret) begin
      r_mie         <= r_mpie;
      r_mpie        <= 1'b1;
    end else if (w_csr_we) begin
      case (imm)
        12'h300: begin
          r_mie  <= wdata[3];
          r_mpie <= wdata[7];
        end
        12'h304: begin
          r_mtie <= wdata[7];
          r_meie <= wdata[11];
        end
        12'h305: r_mtvec    <= {wdata[31:2], 1'b0, wdata[0]};
        12'h340: r_mscratch <= wdata;
        12'h341: r_mepc     <= {wdata[31:2], 2'b00};
        12'h342: begin
          r_mcause_intr <= wdata[31];
          r_mcause_code <= wdata[5:0];
        end
        12'h180: r_satp     <= wdata;
        default: ;
      endcase
    end
  end

  // Cycle and retire counters; a write to either half replaces it and skips that cycle's increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_csr_we && imm == 12'hB00) begin
        r_mcycle[31:0] <= wdata;
      end else if (w_csr_we && imm == 12'hB80) begin
        r_mcycle[CNT_W-1:32] <= wdata[HI_W-1:0];
      end else begin
        r_mcycle <= r_mcycle + CNT_ONE;
      end
      if (w_csr_we && imm == 12'hB02) begin
        r_minstret[31:0] <= wdata;
      end else if (w_csr_we && imm == 12'hB82) begin
        r_minstret[CNT_W-1:32] <= wdata[HI_W-1:0];
      end else if (valid && !w_irq_take) begin
        r_minstret <= r_minstret + CNT_ONE;
      end
    end
  end

  // Synchroniser chain for the asynchronous external interrupt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= irq_ext;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_csr_trap_unit.sv
// Directed bench for the CSR/trap unit: reset state, traps, mret, counters, sync latency, satp and async reset.
// Inputs are driven just after the falling edge; outputs are sampled 1ns later, well away from the rising edge.
// Each comparison goes through chk(); the summary reports passed/total.
module tb_ysyx_23060236_csr_trap_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] imm;
  logic [31:0] wdata;
  logic        enable;
  logic        inst_ecall;
  logic        inst_mret;
  logic [31:0] epc;
  logic        valid;
  logic        irq_timer;
  logic        irq_ext;
  logic [31:0] rdata;
  logic [31:0] jump;
  logic        jump_en;
  logic        irq_take;
  logic        mmu_on;
  logic [19:0] ppn;

  int n_chk  = 0;
  int n_pass = 0;

  ysyx_23060236_csr_trap_unit dut (
    .clock      (clock),
    .reset      (reset),
    .imm        (imm),
    .wdata      (wdata),
    .enable     (enable),
    .inst_ecall (inst_ecall),
    .inst_mret  (inst_mret),
    .epc        (epc),
    .valid      (valid),
    .irq_timer  (irq_timer),
    .irq_ext    (irq_ext),
    .rdata      (rdata),
    .jump       (jump),
    .jump_en    (jump_en),
    .irq_take   (irq_take),
    .mmu_on     (mmu_on),
    .ppn        (ppn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge and return just after the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    imm = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    imm = a; wdata = d; enable = 1'b1; valid = 1'b1;
    step();
    enable = 1'b0; valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imm = 12'h0; wdata = 32'h0; enable = 1'b0; inst_ecall = 1'b0;
    inst_mret = 1'b0; epc = 32'h0; valid = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state and free-running cycle counter
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mie", 12'h304, 32'h0);
    rd("rst_mcycle", 12'hB00, 32'h0);
    chk("rst_jump_en", {31'h0, jump_en}, 32'h0);
    chk("rst_mmu_on", {31'h0, mmu_on}, 32'h0);
    step(); rd("mcycle_1", 12'hB00, 32'd1);
    step(); rd("mcycle_2", 12'hB00, 32'd2);
    step(); rd("mcycle_3", 12'hB00, 32'd3);
    rd("vendor", 12'hF11, 32'h7973_7978);
    rd("arch", 12'hF12, 32'h015f_df0c);

    // Old value visible during write cycle, new value after
    imm = 12'h340; wdata = 32'h0000_1234; enable = 1'b1; valid = 1'b1; #1;
    chk("scratch_old", rdata, 32'h0);
    step(); enable = 1'b0; valid = 1'b0;
    rd("scratch_new", 12'h340, 32'h0000_1234);
    csr_wr(12'h341, 32'h8000_0013);
    rd("mepc_align", 12'h341, 32'h8000_0010);
    csr_wr(12'h7C0, 32'hDEAD_BEEF);
    rd("unmapped", 12'h7C0, 32'h0);

    // Timer interrupt into vectored mtvec
    csr_wr(12'h305, 32'h8000_0103);
    rd("mtvec_bit1", 12'h305, 32'h8000_0101);
    csr_wr(12'h304, 32'h0000_0080);
    csr_wr(12'h300, 32'h0000_0008);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    irq_timer = 1'b1; valid = 1'b1; enable = 1'b1; imm = 12'h340; wdata = 32'h5555_5555;
    epc = 32'h8000_0040; #1;
    chk("tmr_take", {31'h0, irq_take}, 32'h1);
    chk("tmr_jump_en", {31'h0, jump_en}, 32'h1);
    chk("tmr_jump", jump, 32'h8000_011C);
    step(); valid = 1'b0; enable = 1'b0;
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mstatus", 12'h300, 32'h0000_1880);
    rd("tmr_mepc", 12'h341, 32'h8000_0040);
    rd("tmr_wr_dropped", 12'h340, 32'h0000_1234);
    rd("tmr_mip", 12'h344, 32'h0000_0080);
    irq_timer = 1'b0;

    // ecall then mret
    csr_wr(12'h300, 32'h0000_0008);
    valid = 1'b1; inst_ecall = 1'b1; epc = 32'h8000_0010; #1;
    chk("ecall_take", {31'h0, irq_take}, 32'h0);
    chk("ecall_jump_en", {31'h0, jump_en}, 32'h1);
    chk("ecall_jump", jump, 32'h8000_0100);
    step(); valid = 1'b0; inst_ecall = 1'b0;
    rd("ecall_mcause", 12'h342, 32'h0000_000B);
    rd("ecall_mstatus", 12'h300, 32'h0000_1880);
    rd("ecall_mepc", 12'h341, 32'h8000_0010);
    valid = 1'b1; inst_mret = 1'b1; #1;
    chk("mret_jump", jump, 32'h8000_0010);
    chk("mret_jump_en", {31'h0, jump_en}, 32'h1);
    step(); valid = 1'b0; inst_mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // External interrupt through the synchroniser, winning over timer
    csr_wr(12'h304, 32'h0000_0880);
    irq_ext = 1'b1; irq_timer = 1'b1;
    step(); rd("sync_edge1", 12'h344, 32'h0000_0080);
    step(); rd("sync_edge2", 12'h344, 32'h0000_0880);
    valid = 1'b1; epc = 32'h8000_0080; #1;
    chk("ext_take", {31'h0, irq_take}, 32'h1);
    chk("ext_jump", jump, 32'h8000_012C);
    step(); valid = 1'b0;
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    rd("ext_mstatus", 12'h300, 32'h0000_1880);
    irq_ext = 1'b0; irq_timer = 1'b0;
    step(); rd("desync_edge1", 12'h344, 32'h0000_0800);
    step(); rd("desync_edge2", 12'h344, 32'h0000_0000);

    // Counter carry and write-suppresses-increment
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 32'h0000_0000);
    rd("cyc_lo_pre", 12'hB00, 32'hFFFF_FFFF);
    rd("cyc_hi_pre", 12'hB80, 32'h0);
    step();
    rd("cyc_lo_wrap", 12'hB00, 32'h0);
    rd("cyc_hi_carry", 12'hB80, 32'h1);
    csr_wr(12'hB00, 32'h0000_0005);
    rd("cyc_wr5", 12'hB00, 32'd5);
    step(); rd("cyc_6", 12'hB00, 32'd6);
    csr_wr(12'hB02, 32'h0000_0010);
    rd("instret_wr", 12'hB02, 32'h10);
    valid = 1'b1; step(); valid = 1'b0;
    rd("instret_inc", 12'hB02, 32'h11);
    step(); rd("instret_idle", 12'hB02, 32'h11);

    // satp and asynchronous reset during a trap
    csr_wr(12'h180, 32'h8001_2345);
    #1;
    chk("mmu_on", {31'h0, mmu_on}, 32'h1);
    chk("ppn", {12'h0, ppn}, 32'h0001_2345);
    valid = 1'b1; inst_ecall = 1'b1; #1;
    chk("pre_rst_jump_en", {31'h0, jump_en}, 32'h1);
    #1 reset = 1'b1; #1;
    chk("arst_mmu_on", {31'h0, mmu_on}, 32'h0);
    chk("arst_ppn", {12'h0, ppn}, 32'h0);
    chk("arst_jump_en", {31'h0, jump_en}, 32'h0);
    rd("arst_mstatus", 12'h300, 32'h0000_1800);
    rd("arst_mtvec", 12'h305, 32'h0);
    valid = 1'b0; inst_ecall = 1'b0;
    @(negedge clock); reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
